grass_sway_ctrl: RTL and testbench



---
 rtl/grass_pkg.sv | 27 ++
 rtl/frame_edge_det.sv | 35 +++
 rtl/grass_sway_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_grass_sway_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grass_pkg.sv
// -----------------------------------------------------------------------------
// grass_pkg
// Shared definitions for the grass background animation and the renderer's
// blade-bend math.
//   GRASS_OFFSET_W   : width of the sway offset bus
//   GRASS_OFFSET_MIN : default lower bounce bound (inclusive)
//   GRASS_OFFSET_MAX : default upper bounce bound (inclusive)
//   sway_state_e     : animation sequencer states (CALM, GUST)
//   maxInt           : helper for sizing counters from parameters
// -----------------------------------------------------------------------------
package grass_pkg;

  localparam int GRASS_OFFSET_W   = 6;
  localparam int GRASS_OFFSET_MIN = 1;
  localparam int GRASS_OFFSET_MAX = 32;

  typedef enum logic {
    CALM = 1'b0,
    GUST = 1'b1
  } sway_state_e;

  // Larger of two integers; used when sizing counters at elaboration time.
  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/frame_edge_det.sv
// -----------------------------------------------------------------------------
// frame_edge_det
// Registers a same-domain frame sync and produces a one-cycle registered pulse
// on each rising edge. A sync held high produces a single pulse.
// Reusable by any animated layer that needs a per-frame tick.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   sync_i : frame sync level, rising edge marks a new frame
//   tick_o : one-cycle pulse, high the cycle after a rising edge is sampled
// -----------------------------------------------------------------------------
module frame_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_i,
  output logic tick_o
);

  logic sync_q;
  logic tick_q;

  // Remember last cycle's sync level and register the rising-edge compare so
  // that the tick carries no combinational path from the sync input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= sync_i;
      tick_q <= sync_i & ~sync_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/grass_sway_ctrl.sv
// -----------------------------------------------------------------------------
// grass_sway_ctrl
// Animation sequencer for the grass background. Counts frames and moves a sway
// offset back and forth between two bounds. A gust request from game logic
// switches to a timed phase with faster stepping; pause freezes animation.
//
// Optional build macro:
//   GRASS_SWAY_EASE_EN : when defined, frames per step are doubled while the
//                        offset is within EASE_ZONE of either bound, giving an
//                        ease-in/out at the bounce points.
//
// Ports:
//   clk         : pixel clock
//   rst_n       : asynchronous active-low reset
//   frame_sync  : frame sync (same domain), rising edge = new frame
//   pause       : level, freezes counting, offset, direction and gust timer
//   gust_req    : level, held high by game logic until gust_ack is seen
//   gust_ack    : one-cycle pulse when a gust is accepted
//   gust_active : high while in GUST
//   sway_dir    : 1 = offset increasing
//   sway_offset : current sway offset to the renderer
//   frame_tick  : one-cycle pulse per detected frame
// -----------------------------------------------------------------------------
module grass_sway_ctrl
  import grass_pkg::*;
#(
  parameter int OFFSET_W    = GRASS_OFFSET_W,
  parameter int OFFSET_MIN  = GRASS_OFFSET_MIN,
  parameter int OFFSET_MAX  = GRASS_OFFSET_MAX,
  parameter int CALM_FRAMES = 2,
  parameter int GUST_FRAMES = 1,
  parameter int GUST_LEN    = 60,
  parameter int EASE_ZONE   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_sync,
  input  logic                pause,
  input  logic                gust_req,
  output logic                gust_ack,
  output logic                gust_active,
  output logic                sway_dir,
  output logic [OFFSET_W-1:0] sway_offset,
  output logic                frame_tick
);

`ifdef GRASS_SWAY_EASE_EN
  localparam bit EASE_ON = 1'b1;
`else
  localparam bit EASE_ON = 1'b0;
`endif

  // Frame counter must hold up to 2*DIV-1 for the eased divisor.
  localparam int DIV_MAX = maxInt(CALM_FRAMES, GUST_FRAMES);
  localparam int CNT_W   = $clog2(2 * DIV_MAX);
  localparam int LEFT_W  = $clog2(GUST_LEN + 1);

  localparam logic [OFFSET_W-1:0] OFF_MIN    = OFFSET_W'(OFFSET_MIN);
  localparam logic [OFFSET_W-1:0] OFF_MAX    = OFFSET_W'(OFFSET_MAX);
  localparam logic [OFFSET_W-1:0] OFF_MIN_P1 = OFFSET_W'(OFFSET_MIN + 1);
  localparam logic [OFFSET_W-1:0] OFF_MAX_M1 = OFFSET_W'(OFFSET_MAX - 1);
  localparam logic [OFFSET_W-1:0] EASE_LO    = OFFSET_W'(OFFSET_MIN + EASE_ZONE);
  localparam logic [OFFSET_W-1:0] EASE_HI    = OFFSET_W'(OFFSET_MAX - EASE_ZONE);

  localparam logic [CNT_W-1:0] CALM_LAST      = CNT_W'(CALM_FRAMES - 1);
  localparam logic [CNT_W-1:0] CALM_LAST_EASE = CNT_W'(2 * CALM_FRAMES - 1);
  localparam logic [CNT_W-1:0] GUST_LAST      = CNT_W'(GUST_FRAMES - 1);
  localparam logic [CNT_W-1:0] GUST_LAST_EASE = CNT_W'(2 * GUST_FRAMES - 1);

  localparam logic [LEFT_W-1:0] GUST_LEN_V = LEFT_W'(GUST_LEN);
  localparam logic [LEFT_W-1:0] LEFT_ONE   = LEFT_W'(1);

  sway_state_e         state_q;
  logic [CNT_W-1:0]    frmCnt_q;
  logic [LEFT_W-1:0]   gustLeft_q;
  logic [OFFSET_W-1:0] offset_q;
  logic                dir_q;
  logic                ack_q;
  logic                active_q;

  logic                easeActive;
  logic [CNT_W-1:0]    cntLast;
  logic [OFFSET_W-1:0] stepOffset;
  logic                stepDir;
  logic [CNT_W-1:0]    frmCnt_d;
  logic [OFFSET_W-1:0] offset_d;
  logic                dir_d;

  // Frame tick generation lives in the reusable edge detector.
  frame_edge_det u_frame_edge_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .sync_i (frame_sync),
    .tick_o (frame_tick)
  );

  // Next offset/direction for one step of the bounce. The bound itself is
  // shown for exactly one step; the following step already moves away, so
  // the offset never leaves [OFFSET_MIN, OFFSET_MAX].
  always_comb begin
    stepOffset = offset_q;
    stepDir    = dir_q;
    if (dir_q) begin
      if (offset_q == OFF_MAX) begin
        stepDir    = 1'b0;
        stepOffset = OFF_MAX_M1;
      end else begin
        stepOffset = offset_q + 1'b1;
      end
    end else begin
      if (offset_q == OFF_MIN) begin
        stepDir    = 1'b1;
        stepOffset = OFF_MIN_P1;
      end else begin
        stepOffset = offset_q - 1'b1;
      end
    end
  end

  // Frames-per-step for the current state, doubled near the bounds when
  // easing is built in. The ease test looks at the offset before the step.
  // The counter result below is what a counted frame would produce; the FSM
  // decides whether a frame counts at all.
  always_comb begin
    easeActive = EASE_ON && ((offset_q < EASE_LO) || (offset_q > EASE_HI));
    if (state_q == GUST) begin
      cntLast = easeActive ? GUST_LAST_EASE : GUST_LAST;
    end else begin
      cntLast = easeActive ? CALM_LAST_EASE : CALM_LAST;
    end
    if (frmCnt_q >= cntLast) begin
      frmCnt_d = '0;
      offset_d = stepOffset;
      dir_d    = stepDir;
    end else begin
      frmCnt_d = frmCnt_q + 1'b1;
      offset_d = offset_q;
      dir_d    = dir_q;
    end
  end

  // Sequencer FSM. Accepting a gust takes priority over a frame tick arriving
  // in the same cycle, which is simply dropped. In GUST, the last timed frame
  // still steps at gust speed and then the frame counter restarts for CALM.
  // Pause holds everything except the handshake and the state itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CALM;
      frmCnt_q   <= '0;
      gustLeft_q <= '0;
      offset_q   <= OFF_MIN;
      dir_q      <= 1'b1;
      ack_q      <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        CALM: begin
          if (gust_req) begin
            state_q    <= GUST;
            active_q   <= 1'b1;
            ack_q      <= 1'b1;
            gustLeft_q <= GUST_LEN_V;
            frmCnt_q   <= '0;
          end else if (frame_tick && !pause) begin
            frmCnt_q <= frmCnt_d;
            offset_q <= offset_d;
            dir_q    <= dir_d;
          end
        end
        GUST: begin
          if (frame_tick && !pause) begin
            frmCnt_q   <= frmCnt_d;
            offset_q   <= offset_d;
            dir_q      <= dir_d;
            gustLeft_q <= gustLeft_q - 1'b1;
            if (gustLeft_q == LEFT_ONE) begin
              state_q  <= CALM;
              active_q <= 1'b0;
              frmCnt_q <= '0;
            end
          end
        end
        default: begin
          state_q  <= CALM;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign gust_ack    = ack_q;
  assign gust_active = active_q;
  assign sway_dir    = dir_q;
  assign sway_offset = offset_q;

endmodule

// File: tb/tb_grass_sway_ctrl.sv
// -----------------------------------------------------------------------------
// tb_grass_sway_ctrl
// Self-checking bench for grass_sway_ctrl. A behavioural model tracks the sway
// as a position on a triangle wave and counts frames per step from the rules
// of the animation, and every cycle's outputs are compared against it.
// Honors GRASS_SWAY_EASE_EN when the build defines it.
// -----------------------------------------------------------------------------
module tb_grass_sway_ctrl;
  import grass_pkg::*;

  localparam int OFFSET_W    = GRASS_OFFSET_W;
  localparam int OFFSET_MIN  = GRASS_OFFSET_MIN;
  localparam int OFFSET_MAX  = GRASS_OFFSET_MAX;
  localparam int CALM_FRAMES = 2;
  localparam int GUST_FRAMES = 1;
  localparam int GUST_LEN    = 60;
  localparam int EASE_ZONE   = 4;
  localparam int SPAN        = OFFSET_MAX - OFFSET_MIN;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                frame_sync;
  logic                pause;
  logic                gust_req;
  logic                gust_ack;
  logic                gust_active;
  logic                sway_dir;
  logic [OFFSET_W-1:0] sway_offset;
  logic                frame_tick;

  int checks = 0;
  int errors = 0;
  int tickSeen = 0;

  // Model state: the sway is a phase around one full back-and-forth cycle.
  int mPhase;
  bit mFresh;
  int mCnt;
  bit mGust;
  int mLeft;
  bit mSync;
  bit mTick;
  bit mAck;

  grass_sway_ctrl #(
    .OFFSET_W    (OFFSET_W),
    .OFFSET_MIN  (OFFSET_MIN),
    .OFFSET_MAX  (OFFSET_MAX),
    .CALM_FRAMES (CALM_FRAMES),
    .GUST_FRAMES (GUST_FRAMES),
    .GUST_LEN    (GUST_LEN),
    .EASE_ZONE   (EASE_ZONE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_sync  (frame_sync),
    .pause       (pause),
    .gust_req    (gust_req),
    .gust_ack    (gust_ack),
    .gust_active (gust_active),
    .sway_dir    (sway_dir),
    .sway_offset (sway_offset),
    .frame_tick  (frame_tick)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Offset seen at a given phase of the triangle wave.
  function automatic int modelOffset();
    if (mPhase <= SPAN) return OFFSET_MIN + mPhase;
    return OFFSET_MIN + 2 * SPAN - mPhase;
  endfunction

  // Direction: rising half of the wave, or untouched since reset.
  function automatic int modelDir();
    return (mFresh || (mPhase >= 1 && mPhase <= SPAN)) ? 1 : 0;
  endfunction

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPhase = 0;
    mFresh = 1'b1;
    mCnt   = 0;
    mGust  = 1'b0;
    mLeft  = 0;
    mSync  = 1'b0;
    mTick  = 1'b0;
    mAck   = 1'b0;
  endtask

  // One counted frame with the given frames-per-step.
  task automatic modelAdvance(input int div);
    int need;
    need = div;
`ifdef GRASS_SWAY_EASE_EN
    if (modelOffset() < OFFSET_MIN + EASE_ZONE || modelOffset() > OFFSET_MAX - EASE_ZONE)
      need = 2 * div;
`endif
    mCnt++;
    if (mCnt >= need) begin
      mCnt   = 0;
      mPhase = (mPhase + 1) % (2 * SPAN);
      mFresh = 1'b0;
    end
  endtask

  // Model reaction to one rising clock edge with the given inputs.
  task automatic modelStep(input logic fs, input logic ps, input logic rq);
    bit tickNow;
    tickNow = mTick;
    mTick   = fs && !mSync;
    mSync   = fs;
    mAck    = 1'b0;
    if (!mGust) begin
      if (rq) begin
        mGust = 1'b1;
        mAck  = 1'b1;
        mLeft = GUST_LEN;
        mCnt  = 0;
      end else if (tickNow && !ps) begin
        modelAdvance(CALM_FRAMES);
      end
    end else if (tickNow && !ps) begin
      modelAdvance(GUST_FRAMES);
      mLeft--;
      if (mLeft == 0) begin
        mGust = 1'b0;
        mCnt  = 0;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("frame_tick", 32'(frame_tick), 32'(mTick));
    checkOutput("gust_ack", 32'(gust_ack), 32'(mAck));
    checkOutput("gust_active", 32'(gust_active), 32'(mGust));
    checkOutput("sway_dir", 32'(sway_dir), 32'(modelDir()));
    checkOutput("sway_offset", 32'(sway_offset), 32'(modelOffset()));
    checkOutput("offset_range",
                32'((sway_offset >= OFFSET_MIN) && (sway_offset <= OFFSET_MAX)), 32'd1);
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic applyStimulus(input logic fs, input logic ps, input logic rq);
    @(negedge clk);
    frame_sync = fs;
    pause      = ps;
    gust_req   = rq;
    @(posedge clk);
    modelStep(fs, ps, rq);
    #1;
    if (frame_tick) tickSeen++;
    compareAll();
  endtask

  // One frame: a single high cycle on frame_sync followed by two low cycles.
  task automatic frameEdge(input logic ps, input logic rq);
    applyStimulus(1'b1, ps, rq);
    applyStimulus(1'b0, ps, rq);
    applyStimulus(1'b0, ps, rq);
  endtask

  // Synchronous-looking entry into reset, checked before the next edge.
  task automatic resetDut();
    @(negedge clk);
    frame_sync = 1'b0;
    pause      = 1'b0;
    gust_req   = 1'b0;
    rst_n      = 1'b0;
    modelReset();
    #1;
    compareAll();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int snapOffset;
    int snapLeft;
    int snapDir;
    int syncTimer;
    bit syncLvl;
    bit req;
    bit ps;
    bit found;

    rst_n      = 1'b0;
    frame_sync = 1'b0;
    pause      = 1'b0;
    gust_req   = 1'b0;
    modelReset();
    #12;
    checkOutput("reset_offset", 32'(sway_offset), OFFSET_MIN);
    checkOutput("reset_dir", 32'(sway_dir), 32'd1);
    checkOutput("reset_active", 32'(gust_active), 32'd0);
    checkOutput("reset_ack", 32'(gust_ack), 32'd0);
    checkOutput("reset_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Eight calm frames from reset; held sync gives one tick per frame.
    $display("[TB] calm stepping from reset");
    tickSeen = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("calm_ticks", tickSeen, 32'd8);
`ifdef GRASS_SWAY_EASE_EN
    checkOutput("calm_offset", 32'(sway_offset), 32'd3);
`else
    checkOutput("calm_offset", 32'(sway_offset), 32'd5);
`endif
    checkOutput("calm_dir", 32'(sway_dir), 32'd1);

    // Gust request arriving in the same cycle as a frame tick.
    $display("[TB] gust accepted alongside a frame tick");
    snapOffset = modelOffset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("same_cycle_ack", 32'(gust_ack), 32'd1);
    checkOutput("same_cycle_active", 32'(gust_active), 32'd1);
    checkOutput("same_cycle_nostep", 32'(sway_offset), 32'(snapOffset));
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ack_one_cycle", 32'(gust_ack), 32'd0);
    frameEdge(1'b0, 1'b0);
`ifndef GRASS_SWAY_EASE_EN
    checkOutput("gust_first_step", 32'(sway_offset), 32'(snapOffset + 1));
`endif

    // Pause across ten frames in the middle of the gust.
    $display("[TB] pause mid-gust");
    repeat (4) frameEdge(1'b0, 1'b0);
    snapOffset = modelOffset();
    snapDir    = modelDir();
    snapLeft   = mLeft;
    tickSeen   = 0;
    repeat (10) frameEdge(1'b1, 1'b0);
    checkOutput("pause_ticks", tickSeen, 32'd10);
    checkOutput("pause_offset", 32'(sway_offset), 32'(snapOffset));
    checkOutput("pause_dir", 32'(sway_dir), 32'(snapDir));
    checkOutput("pause_left", mLeft, 32'(snapLeft));
    checkOutput("pause_active", 32'(gust_active), 32'd1);
    repeat (snapLeft - 1) frameEdge(1'b0, 1'b0);
    checkOutput("gust_last_tick_active", 32'(gust_active), 32'd1);
    frameEdge(1'b0, 1'b0);
    checkOutput("gust_ended", 32'(gust_active), 32'd0);

    // Randomized traffic: ragged sync, occasional pause, handshake requests.
    $display("[TB] randomized traffic");
    syncTimer = 1;
    syncLvl   = 1'b0;
    req       = 1'b0;
    ps        = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      syncTimer--;
      if (syncTimer == 0) begin
        syncLvl   = ~syncLvl;
        syncTimer = syncLvl ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 4));
      end
      if ($urandom_range(0, 39) == 0) ps = ~ps;
      if (ps && $urandom_range(0, 7) == 0) ps = 1'b0;
      if (!req) begin
        req = ($urandom_range(0, 299) == 0);
      end else if (mAck && $urandom_range(0, 3) != 0) begin
        req = 1'b0;
      end
      applyStimulus(syncLvl, ps, req);
    end

    // Asynchronous reset in the middle of a gust at offset 20.
    $display("[TB] reset mid-gust");
    resetDut();
    applyStimulus(1'b0, 1'b0, 1'b1);
    found = 1'b0;
    for (int f = 0; f < 200 && !found; f++) begin
      frameEdge(1'b0, 1'b0);
      if (mGust && modelOffset() == 20) found = 1'b1;
    end
    checkOutput("reach_offset_20", 32'(found), 32'd1);
    @(posedge clk);
    modelStep(1'b0, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_offset", 32'(sway_offset), OFFSET_MIN);
    checkOutput("async_dir", 32'(sway_dir), 32'd1);
    checkOutput("async_active", 32'(gust_active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) frameEdge(1'b0, 1'b0);
    checkOutput("post_reset_calm", 32'(gust_active), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
